// File: rtl/connect_scan.sv
// connect_scan: streaming Connect-N win detector over a full board scan.
// Takes one row per valid/ready beat (bottom row first) and keeps the last
// WIN_LEN-1 rows in a shift window. Every accepted row is checked for
// horizontal, vertical and (optional) diagonal lines. Results are sticky
// until the next start.
// Ports: clk, rst_n (async, active-low); start (restart pulse);
//   row_valid/row_ready/row_data (row stream, 2 bits per cell:
//   01=G 10=O 00=empty 11=illegal);
//   busy, done (scan status); g_win, o_win, win_row, bad_cell (results).
// Build option: define CONNECT_SCAN_DIAG_EN to include the diagonal checks.
module connect_scan #(
   parameter int COLS    = 7,
   parameter int ROWS    = 6,
   parameter int WIN_LEN = 4,
   parameter int RW      = $clog2(ROWS)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              row_valid,
   output logic              row_ready,
   input  logic [2*COLS-1:0] row_data,
   output logic              busy,
   output logic              done,
   output logic              g_win,
   output logic              o_win,
   output logic [RW-1:0]     win_row,
   output logic              bad_cell
);

   localparam int OFFS = COLS - WIN_LEN + 1;
   localparam int BD   = WIN_LEN - 1;

   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_e;

   state_e              state_q, state_d;
   logic [2*COLS-1:0]   buf_q [BD];
   logic [RW-1:0]       cnt_q;
   logic                g_win_q, o_win_q, bad_q;
   logic [RW-1:0]       win_row_q;

   logic                acc;
   logic                last;
   logic [2*COLS-1:0]   win [WIN_LEN];
   logic [OFFS-1:0]     hg, ho;
   logic [COLS-1:0]     vg, vo;
   logic                bad;
   logic                g_hit, o_hit;

   function automatic logic is_g(input logic [1:0] c);
      return c == 2'b01;
   endfunction

   function automatic logic is_o(input logic [1:0] c);
      return c == 2'b10;
   endfunction

   assign acc  = row_valid && (state_q == SCAN);
   assign last = (cnt_q == RW'(ROWS - 1));

   // win[0] is the incoming row, win[k] the row accepted k beats ago
   always_comb begin
      win[0] = row_data;
      for (int k = 1; k < WIN_LEN; k++) begin
         win[k] = buf_q[k-1];
      end
   end

   always_comb begin
      hg  = '1;
      ho  = '1;
      vg  = '1;
      vo  = '1;
      bad = 1'b0;
      for (int o = 0; o < OFFS; o++) begin
         for (int k = 0; k < WIN_LEN; k++) begin
            hg[o] = hg[o] & is_g(row_data[2*(o+k) +: 2]);
            ho[o] = ho[o] & is_o(row_data[2*(o+k) +: 2]);
         end
      end
      for (int c = 0; c < COLS; c++) begin
         for (int k = 0; k < WIN_LEN; k++) begin
            vg[c] = vg[c] & is_g(win[k][2*c +: 2]);
            vo[c] = vo[c] & is_o(win[k][2*c +: 2]);
         end
         bad = bad | (&row_data[2*c +: 2]);
      end
   end

`ifdef CONNECT_SCAN_DIAG_EN
   logic [OFFS-1:0] ug, uo, dg, dox;

   // u: column falls with age (rising toward newer rows to the right);
   // d: column rises with age
   always_comb begin
      ug  = '1;
      uo  = '1;
      dg  = '1;
      dox = '1;
      for (int o = 0; o < OFFS; o++) begin
         for (int k = 0; k < WIN_LEN; k++) begin
            ug[o]  = ug[o]  & is_g(win[k][2*(o+WIN_LEN-1-k) +: 2]);
            uo[o]  = uo[o]  & is_o(win[k][2*(o+WIN_LEN-1-k) +: 2]);
            dg[o]  = dg[o]  & is_g(win[k][2*(o+k) +: 2]);
            dox[o] = dox[o] & is_o(win[k][2*(o+k) +: 2]);
         end
      end
   end

   assign g_hit = (|hg) | (|vg) | (|ug) | (|dg);
   assign o_hit = (|ho) | (|vo) | (|uo) | (|dox);
`else
   assign g_hit = (|hg) | (|vg);
   assign o_hit = (|ho) | (|vo);
`endif

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (start) state_d = SCAN;
         SCAN: begin
            if (start)             state_d = SCAN;
            else if (acc && last)  state_d = DONE;
         end
         DONE: if (start) state_d = SCAN;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < BD; k++) buf_q[k] <= '0;
         cnt_q     <= '0;
         g_win_q   <= 1'b0;
         o_win_q   <= 1'b0;
         bad_q     <= 1'b0;
         win_row_q <= '0;
      end else if (start) begin
         for (int k = 0; k < BD; k++) buf_q[k] <= '0;
         cnt_q     <= '0;
         g_win_q   <= 1'b0;
         o_win_q   <= 1'b0;
         bad_q     <= 1'b0;
         win_row_q <= '0;
      end else if (acc) begin
         buf_q[0] <= row_data;
         for (int k = 1; k < BD; k++) buf_q[k] <= buf_q[k-1];
         cnt_q   <= cnt_q + RW'(1);
         g_win_q <= g_win_q | g_hit;
         o_win_q <= o_win_q | o_hit;
         bad_q   <= bad_q | bad;
         // freeze on the first winning beat
         if ((g_hit || o_hit) && !(g_win_q || o_win_q)) begin
            win_row_q <= cnt_q;
         end
      end
   end

   assign row_ready = (state_q == SCAN);
   assign busy      = (state_q == SCAN);
   assign done      = (state_q == DONE);
   assign g_win     = g_win_q;
   assign o_win     = o_win_q;
   assign win_row   = win_row_q;
   assign bad_cell  = bad_q;

endmodule

// File: tb/tb_connect_scan.sv
// tb_connect_scan: directed self-checking bench for connect_scan
// (COLS=7, ROWS=6, WIN_LEN=4).
module tb_connect_scan;

   localparam int COLS = 7;
   localparam int ROWS = 6;
   localparam int RW   = 3;

   logic              clk;
   logic              rst_n;
   logic              start;
   logic              row_valid;
   logic              row_ready;
   logic [2*COLS-1:0] row_data;
   logic              busy;
   logic              done;
   logic              g_win;
   logic              o_win;
   logic [RW-1:0]     win_row;
   logic              bad_cell;

   int checks;
   int errors;
   int acc_cnt;
   int acc_base;

   connect_scan #(.COLS(COLS), .ROWS(ROWS), .WIN_LEN(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .row_valid (row_valid),
      .row_ready (row_ready),
      .row_data  (row_data),
      .busy      (busy),
      .done      (done),
      .g_win     (g_win),
      .o_win     (o_win),
      .win_row   (win_row),
      .bad_cell  (bad_cell)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial acc_cnt = 0;
   always @(posedge clk) begin
      if (row_valid && row_ready) acc_cnt = acc_cnt + 1;
   end

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic send(input logic [2*COLS-1:0] d);
      row_valid = 1'b1;
      row_data  = d;
      tick();
      row_valid = 1'b0;
      row_data  = '0;
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      rst_n     = 1'b0;
      start     = 1'b0;
      row_valid = 1'b0;
      row_data  = '0;
      #12;
      chk("rst_ready", row_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_gwin", g_win, 0);
      chk("rst_owin", o_win, 0);
      chk("rst_row", win_row, 0);
      chk("rst_bad", bad_cell, 0);
      rst_n = 1'b1;
      tick();
      chk("idle_ready", row_ready, 0);

      // horizontal G in row 0
      do_start();
      chk("h_ready", row_ready, 1);
      chk("h_busy", busy, 1);
      send(14'h0055);
      chk("h_gwin", g_win, 1);
      chk("h_row", win_row, 0);
      chk("h_owin", o_win, 0);
      chk("h_done_early", done, 0);
      for (int r = 1; r < ROWS; r++) send(14'h0000);
      chk("h_done", done, 1);
      chk("h_busy_end", busy, 0);
      chk("h_ready_end", row_ready, 0);
      chk("h_gwin_end", g_win, 1);

      // vertical O in column 2, rows 1-4
      do_start();
      chk("v_clr_gwin", g_win, 0);
      chk("v_clr_done", done, 0);
      send(14'h0000);
      for (int r = 1; r <= 3; r++) send(14'h0020);
      chk("v_owin_b3", o_win, 0);
      send(14'h0020);
      chk("v_owin", o_win, 1);
      chk("v_row", win_row, 4);
      chk("v_gwin", g_win, 0);
      send(14'h0000);
      chk("v_done", done, 1);

      // rising diagonal G at (r, r), r = 0-3
      do_start();
      send(14'h0001);
      send(14'h0004);
      send(14'h0010);
      chk("d_gwin_b2", g_win, 0);
      send(14'h0040);
`ifdef CONNECT_SCAN_DIAG_EN
      chk("d_gwin", g_win, 1);
      chk("d_row", win_row, 3);
`else
      chk("d_gwin", g_win, 0);
      chk("d_row", win_row, 0);
`endif
      send(14'h0000);
      send(14'h0000);
      chk("d_done", done, 1);

      // vertical three, illegal cell, stalls
      do_start();
      acc_base = acc_cnt;
      send(14'h0001);
      tick();
      chk("s_stall_busy", busy, 1);
      send(14'h0001);
      send(14'h0001);
      tick();
      send(14'h0000);
      send(14'h0000);
      chk("s_bad_pre", bad_cell, 0);
      chk("s_done_pre", done, 0);
      send(14'h3000);
      send(14'h0055);
      chk("s_accepts", acc_cnt - acc_base, 6);
      chk("s_gwin", g_win, 0);
      chk("s_owin", o_win, 0);
      chk("s_bad", bad_cell, 1);
      chk("s_done", done, 1);

      // G horizontal and O vertical both complete on beat 3
      do_start();
      for (int r = 0; r < 3; r++) send(14'h0800);
      chk("b_gwin_pre", g_win, 0);
      chk("b_owin_pre", o_win, 0);
      send(14'h0855);
      chk("b_gwin", g_win, 1);
      chk("b_owin", o_win, 1);
      chk("b_row", win_row, 3);
      send(14'h0055);
      chk("b_row_frozen", win_row, 3);
      // restart mid-scan with a row offered in the same cycle
      start     = 1'b1;
      row_valid = 1'b1;
      row_data  = 14'h0055;
      tick();
      start     = 1'b0;
      row_valid = 1'b0;
      row_data  = '0;
      chk("r_gwin", g_win, 0);
      chk("r_owin", o_win, 0);
      chk("r_row", win_row, 0);
      chk("r_busy", busy, 1);
      for (int r = 0; r < ROWS - 1; r++) send(14'h0000);
      chk("r_dropped", done, 0);
      send(14'h0000);
      chk("r_done", done, 1);
      chk("r_gwin_end", g_win, 0);

      // async reset mid-scan
      do_start();
      for (int r = 0; r < 4; r++) send(14'h0001);
      chk("m_gwin", g_win, 1);
      chk("m_row", win_row, 3);
      #2;
      rst_n = 1'b0;
      #1;
      chk("m_busy", busy, 0);
      chk("m_ready", row_ready, 0);
      chk("m_gwin_rst", g_win, 0);
      chk("m_row_rst", win_row, 0);
      chk("m_done", done, 0);
      #3;
      rst_n = 1'b1;
      tick();
      chk("m_idle", row_ready, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
